// File: rtl/tcdm_bank_responder.sv
`default_nettype none
// ============================================================================
// Module   : tcdm_bank_responder
// Brief    : TCDM slave bank: combinational grant, byte-enabled word memory,
//            fixed-latency response pipeline.
// Revision : 1.0
// ============================================================================
module tcdm_bank_responder #(
    parameter int unsigned ADDR_WIDTH    = 8,
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned RESP_LAT      = 1,
    parameter bit          WRITE_RESP_ON = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    stall_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   add_i,
    input  logic                    wen_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o,
    output logic                    resp_vld_o
);

    localparam int unsigned NUM_WORDS = 2 ** ADDR_WIDTH;
    localparam int unsigned BE_WIDTH  = DATA_WIDTH / 8;

    if ((RESP_LAT < 1) || (RESP_LAT > 8)) begin : g_bad_resp_lat
        $fatal(1, "tcdm_bank_responder: RESP_LAT must be in 1..8");
    end

    if ((DATA_WIDTH % 8) != 0) begin : g_bad_data_width
        $fatal(1, "tcdm_bank_responder: DATA_WIDTH must be a multiple of 8");
    end

    logic                  accept;
    logic                  rd_accept;
    logic                  resp_load;

    logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

    logic [RESP_LAT-1:0]   vld_q;
    logic [RESP_LAT-1:0]   rd_q;
    logic [DATA_WIDTH-1:0] data_q [RESP_LAT];

    always_comb begin
        gnt_o     = req_i & ~stall_i & rst_ni;
        accept    = req_i & gnt_o;
        rd_accept = accept & ~wen_i;
        resp_load = accept & (~wen_i | WRITE_RESP_ON);
    end

    // Storage is deliberately left out of reset so contents survive it.
    always_ff @(posedge clk_i) begin
        if (accept && wen_i) begin
            for (int k = 0; k < BE_WIDTH; k++) begin
                if (be_i[k]) begin
                    mem[add_i][8*k +: 8] <= wdata_i[8*k +: 8];
                end
            end
        end
    end

    // Data stages advance only behind a read, so the last stage keeps the
    // most recently returned read word between read responses.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            vld_q <= '0;
            rd_q  <= '0;
            for (int i = 0; i < RESP_LAT; i++) begin
                data_q[i] <= '0;
            end
        end else begin
            vld_q[0] <= resp_load;
            rd_q[0]  <= rd_accept;
            if (rd_accept) begin
                data_q[0] <= mem[add_i];
            end
            for (int i = 1; i < RESP_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                rd_q[i]  <= rd_q[i-1];
                if (rd_q[i-1]) begin
                    data_q[i] <= data_q[i-1];
                end
            end
        end
    end

    assign rdata_o    = data_q[RESP_LAT-1];
    assign resp_vld_o = vld_q[RESP_LAT-1];

endmodule
`default_nettype wire

// File: tb/tb_tcdm_bank_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_tcdm_bank_responder
// Brief    : Scoreboard bench driving three bank configurations.
// Revision : 1.0
// ============================================================================
module tb_tcdm_bank_responder;

    localparam int ND = 3;

    typedef struct {
        int          d;
        int          due;
        bit          rd;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall [ND];
    logic        req   [ND];
    logic        wen   [ND];
    logic        gnt   [ND];
    logic        rvld  [ND];
    logic [7:0]  add   [ND];
    logic [3:0]  be    [ND];
    logic [31:0] wdata [ND];
    logic [31:0] rdata [ND];

    exp_t        sb [$];
    logic [31:0] mdl [ND][256];
    logic [31:0] last_rd [ND];
    int          n_chk  = 0;
    int          n_pass = 0;
    int          cnt    = 0;
    bit          mon_en = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cnt <= cnt + 1;

    tcdm_bank_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RESP_LAT(1), .WRITE_RESP_ON(1'b1)) u_d0 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall[0]), .req_i(req[0]), .gnt_o(gnt[0]),
        .add_i(add[0]), .wen_i(wen[0]), .be_i(be[0]), .wdata_i(wdata[0]),
        .rdata_o(rdata[0]), .resp_vld_o(rvld[0]));

    tcdm_bank_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RESP_LAT(3), .WRITE_RESP_ON(1'b1)) u_d1 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall[1]), .req_i(req[1]), .gnt_o(gnt[1]),
        .add_i(add[1]), .wen_i(wen[1]), .be_i(be[1]), .wdata_i(wdata[1]),
        .rdata_o(rdata[1]), .resp_vld_o(rvld[1]));

    tcdm_bank_responder #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .RESP_LAT(2), .WRITE_RESP_ON(1'b0)) u_d2 (
        .clk_i(clk), .rst_ni(rst_n), .stall_i(stall[2]), .req_i(req[2]), .gnt_o(gnt[2]),
        .add_i(add[2]), .wen_i(wen[2]), .be_i(be[2]), .wdata_i(wdata[2]),
        .rdata_o(rdata[2]), .resp_vld_o(rvld[2]));

    function automatic int lat_of(input int d);
        case (d)
            0:       return 1;
            1:       return 3;
            default: return 2;
        endcase
    endfunction

    function automatic bit wro_of(input int d);
        return (d != 2);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cnt);
    endtask

    // Called just before the accepting posedge, so cnt+lat is the due cycle.
    task automatic push_exp(input int d, input bit w, input logic [7:0] a,
                            input logic [3:0] b, input logic [31:0] wd);
        exp_t e;
        e.d    = d;
        e.due  = cnt + lat_of(d);
        e.rd   = !w;
        e.data = mdl[d][a];
        if (w) begin
            for (int k = 0; k < 4; k++)
                if (b[k]) mdl[d][a][8*k +: 8] = wd[8*k +: 8];
            e.data = '0;
            if (wro_of(d)) sb.push_back(e);
        end else begin
            sb.push_back(e);
        end
    endtask

    task automatic do_acc(input int d, input bit w, input logic [7:0] a,
                          input logic [3:0] b, input logic [31:0] wd);
        bit ok;
        ok = 1'b0;
        @(negedge clk); #2;
        req[d] = 1'b1; wen[d] = w; add[d] = a; be[d] = b; wdata[d] = wd;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (gnt[d]) ok = 1'b1;
            else begin @(negedge clk); #2; end
        end
        if (!ok) check("gnt_timeout", 32'd0, 32'd1);
        else begin
            push_exp(d, w, a, b, wd);
            @(posedge clk);
        end
        #1;
        req[d] = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    always @(negedge clk) begin
        bit hit;
        if (mon_en) begin
            for (int d = 0; d < ND; d++) begin
                hit = 1'b0;
                for (int i = 0; i < sb.size(); i++) begin
                    if (sb[i].d == d && sb[i].due == cnt) begin
                        hit = 1'b1;
                        if (sb[i].rd) last_rd[d] = sb[i].data;
                        sb.delete(i);
                        break;
                    end
                end
                check($sformatf("resp_vld[%0d]", d), 32'(rvld[d]), 32'(hit));
                check($sformatf("rdata[%0d]", d), rdata[d], last_rd[d]);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int d = 0; d < ND; d++) begin
            stall[d] = 1'b0; req[d] = 1'b0; wen[d] = 1'b0; add[d] = '0;
            be[d] = '0; wdata[d] = '0; last_rd[d] = '0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        req[0] = 1'b1;
        #1;
        check("gnt_in_reset", 32'(gnt[0]), 32'd0);
        req[0] = 1'b0;
        mon_en = 1'b1;
        @(negedge clk); #2;
        rst_n = 1'b1;
        idle(2);

        // Full write then read back with single-cycle latency
        do_acc(0, 1'b1, 8'h10, 4'hF, 32'hDEADBEEF);
        do_acc(0, 1'b0, 8'h10, 4'h0, 32'h0);
        idle(3);
        check("t1_rdata", rdata[0], 32'hDEADBEEF);

        // Partial byte-enable overwrite
        do_acc(0, 1'b1, 8'h03, 4'hF, 32'h11223344);
        do_acc(0, 1'b1, 8'h03, 4'b0101, 32'hAABBCCDD);
        do_acc(0, 1'b0, 8'h03, 4'h0, 32'h0);
        idle(3);
        check("t2_rdata", rdata[0], 32'h11BB33DD);

        // Back-to-back reads through a three-stage pipeline
        for (int i = 1; i <= 3; i++) do_acc(1, 1'b1, 8'(i), 4'hF, 32'(i));
        idle(4);
        for (int i = 1; i <= 3; i++) do_acc(1, 1'b0, 8'(i), 4'h0, 32'h0);
        idle(5);
        check("t3_rdata", rdata[1], 32'd3);

        // Stall with a read response still in flight
        do_acc(1, 1'b0, 8'h01, 4'h0, 32'h0);
        @(negedge clk); #2;
        stall[1] = 1'b1; req[1] = 1'b1; wen[1] = 1'b1; add[1] = 8'h05;
        be[1] = 4'hF; wdata[1] = 32'hCAFE0005;
        repeat (4) begin
            #1;
            check("stall_gnt", 32'(gnt[1]), 32'd0);
            @(negedge clk); #2;
        end
        stall[1] = 1'b0;
        #1;
        check("unstall_gnt", 32'(gnt[1]), 32'd1);
        if (gnt[1]) push_exp(1, 1'b1, 8'h05, 4'hF, 32'hCAFE0005);
        @(posedge clk); #1;
        req[1] = 1'b0;
        do_acc(1, 1'b0, 8'h05, 4'h0, 32'h0);
        idle(5);
        check("t4_rdata", rdata[1], 32'hCAFE0005);

        // Write responses: silent on d2, pulsing with rdata held on d0
        do_acc(2, 1'b1, 8'h07, 4'hF, 32'h00000055);
        do_acc(0, 1'b1, 8'h20, 4'hF, 32'h12345678);
        idle(4);
        check("t6_rdata_held", rdata[0], 32'h11BB33DD);

        // Reset while a read is in flight drops its response
        do_acc(2, 1'b0, 8'h07, 4'h0, 32'h0);
        @(negedge clk); #2;
        rst_n = 1'b0;
        sb.delete();
        for (int d = 0; d < ND; d++) last_rd[d] = '0;
        idle(2);
        check("t5_rdata_reset", rdata[2], 32'd0);
        #2;
        rst_n = 1'b1;
        idle(2);
        do_acc(2, 1'b0, 8'h07, 4'h0, 32'h0);
        idle(4);
        check("t5_mem_kept", rdata[2], 32'h00000055);

        idle(2);
        mon_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
